alu_share_arb: RTL and testbench
================================

# alu_share_arb

Round-robin arbiter and sequencer that shares one registered 8-bit ALU among N requesters. Each requester presents an operation (ctl, a, b) over a valid/ready handshake. The block issues one operation at a time to the ALU, waits out the ALU's one-cycle register latency, and returns the result with the winning requester's id over a valid/ready response channel. It sits between the requester ports and the ALU's ctl/a/b/q/cout pins. It also screens divide-by-zero.

## Interface
- N, 4, number of requesters (2..8); IDW = $clog2(N)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester accept, one-hot or zero
- req_ctl  in  3N  op code per requester, slice i = [3i+2:3i]
- req_a  in  8N  operand a per requester, slice i = [8i+7:8i]
- req_b  in  8N  operand b per requester, slice i = [8i+7:8i]
- alu_ctl  out  3  to ALU ctl
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_q  in  8  from ALU q, registered in ALU
- alu_cout  in  1  from ALU cout
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of requester served
- rsp_q  out  8  result low byte
- rsp_cout  out  1  result bit 8
- rsp_err  out  1  divide-by-zero flag
- busy  out  1  state != IDLE
- ops_done  out  16  completed responses, wraps at 16'hFFFF -> 0

## Operation
- FSM states: IDLE, EXEC, WAIT, RESP.
- **IDLE**
  - Grant goes to the first requester with req_valid = 1, searching from ptr+1 upward modulo N.
  - req_ready[g] = 1 combinationally, only in IDLE. No valid requester gives req_ready = 0.
  - On the edge:
    - latch ctl/a/b into operand registers and g into id register
    - set ptr <= g
    - set div0 <= (ctl == 3'b011 && b == 0)
    - go to EXEC
- **EXEC**
  - alu_ctl/alu_a/alu_b are driven from the operand registers, which are stable through EXEC and WAIT.
  - If div0, alu_ctl is forced to 3'b000.
  - Next edge goes to WAIT. The ALU registers its result on this edge.
- **WAIT**
  - alu_q/alu_cout are valid.
  - On the edge:
    - rsp_q <= div0 ? 8'hFF : alu_q
    - rsp_cout <= div0 ? 0 : alu_cout
    - rsp_err <= div0
    - rsp_id <= id
    - rsp_valid <= 1
    - go to RESP
- **RESP**
  - Hold all rsp_* outputs stable while rsp_valid = 1 && rsp_ready = 0.
  - On the edge with rsp_ready = 1: rsp_valid <= 0, ops_done++, go to IDLE.
- Op codes 100-111 pass through unmodified; the ALU treats them as add.
- The block performs no arithmetic except the div0 compare. All results come from the ALU.
- Requester rules: hold req_valid and payload until req_ready. Dropping valid before the grant is illegal, and the block's behaviour is then undefined.

## Timing
- Reset values:
  - state IDLE
  - ptr = N-1, so requester 0 has first priority
  - req_ready = 0, as a consequence of IDLE with no valid request
  - alu_ctl/alu_a/alu_b = 0
  - rsp_valid = 0, rsp_id = 0, rsp_q = 0, rsp_cout = 0, rsp_err = 0
  - busy = 0
  - ops_done = 0
- Latency:
  - accept edge e0, rsp_valid high after e2 (2 cycles)
  - minimum issue interval 4 cycles: IDLE, EXEC, WAIT, RESP with rsp_ready held 1
- A new request is never granted in RESP, even when rsp_ready = 1 on the same cycle. The grant happens in the following IDLE cycle.
- Simultaneous requests: exactly one grant per IDLE cycle, round-robin. Each of N always-valid requesters is served once every N operations.
- A requester raising valid during EXEC/WAIT/RESP waits. Its req_ready stays 0.
- Reset asserted mid-operation returns all state to the reset values immediately (asynchronous). The in-flight op is dropped and no response is produced.

## Test plan
- **Add with carry:** req0 ctl=000, a=200, b=100 -> req_ready[0] same cycle; rsp_valid 2 cycles after accept; rsp_id=0, rsp_q=8'h2C, rsp_cout=1, rsp_err=0, ops_done=1.
- **Round-robin:** req0..req3 all valid continuously, each ctl=001 with a=5, b=7 -> grant order 0,1,2,3,0; every rsp_q=8'hFE, rsp_cout=1; 4-cycle spacing with rsp_ready=1.
- **Divide-by-zero:** req2 ctl=011, a=9, b=0 -> alu_ctl=000 during EXEC; rsp_id=2, rsp_q=8'hFF, rsp_cout=0, rsp_err=1. Follow with a=9, b=2 -> rsp_q=4, rsp_err=0.
- **Backpressure:** req1 ctl=010, a=16, b=17 with rsp_ready=0 for 5 cycles -> rsp_q=8'h10, rsp_cout=1 held stable; req0 valid meanwhile sees req_ready=0; req0 is served only after the response handshake.
- **Reset mid-op:** assert rst_n=0 during WAIT -> all outputs take reset values at once; after release, with req3 and req0 valid, req0 is granted first.
- **Counter wrap:** preload by running 65536 ops (or force ops_done to 16'hFFFF) -> next completion gives ops_done=0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one registered 8-bit ALU among N requesters.
// Issues one op at a time, waits out the ALU latency, and returns the result with the winner's id.
module alu_share_arb #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [3*N-1:0]  req_ctl,
    input  logic [8*N-1:0]  req_a,
    input  logic [8*N-1:0]  req_b,
    output logic [2:0]      alu_ctl,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    input  logic [7:0]      alu_q,
    input  logic            alu_cout,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [7:0]      rsp_q,
    output logic            rsp_cout,
    output logic            rsp_err,
    output logic            busy,
    output logic [15:0]     ops_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  id_q;
    logic            div0_q;
    logic [2:0]      alu_ctl_q;
    logic [7:0]      alu_a_q;
    logic [7:0]      alu_b_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [7:0]      rsp_q_q;
    logic            rsp_cout_q;
    logic            rsp_err_q;
    logic [15:0]     ops_done_q;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic [2:0]      sel_ctl;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;
    logic            sel_div0;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((32'(ptr_q) + 32'(k)) % 32'(N));
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_ctl   = '0;
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_ctl = req_ctl[3*i +: 3];
                sel_a   = req_a[8*i +: 8];
                sel_b   = req_b[8*i +: 8];
            end
            req_ready[i] = (state_q == S_IDLE) && grant_found && (grant_idx == IDW'(i));
        end
    end

    assign sel_div0 = (sel_ctl == 3'b011) && (sel_b == 8'h00);

    // A zero divisor is turned into a harmless add so the ALU never sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(N - 1);
            id_q        <= '0;
            div0_q      <= 1'b0;
            alu_ctl_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        alu_ctl_q <= sel_div0 ? 3'b000 : sel_ctl;
                        alu_a_q   <= sel_a;
                        alu_b_q   <= sel_b;
                        div0_q    <= sel_div0;
                        id_q      <= grant_idx;
                        ptr_q     <= grant_idx;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    rsp_q_q     <= div0_q ? 8'hFF : alu_q;
                    rsp_cout_q  <= div0_q ? 1'b0 : alu_cout;
                    rsp_err_q   <= div0_q;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ops_done_q  <= ops_done_q + 16'd1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_ctl   = alu_ctl_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE);
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural registered ALU
// (000 add, 001 sub, 010 mul, 011 div, 1xx add; bit 8 of the result is cout).
module tb_alu_share_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_ctl;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  alu_ctl;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_q;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_q;
    logic        rsp_cout;
    logic        rsp_err;
    logic        busy;
    logic [15:0] ops_done;

    int errors = 0;
    int checks = 0;

    alu_share_arb #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctl   (req_ctl),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_ctl   (alu_ctl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_q     (alu_q),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU with one register stage, independent of the arbiter.
    logic [15:0] prod;
    logic [8:0]  alu_res;
    always_comb begin
        prod    = 16'(alu_a) * 16'(alu_b);
        alu_res = 9'd0;
        case (alu_ctl)
            3'b001:  alu_res = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  alu_res = prod[8:0];
            3'b011:  alu_res = (alu_b == 8'd0) ? 9'h0FF : {1'b0, alu_a / alu_b};
            default: alu_res = {1'b0, alu_a} + {1'b0, alu_b};
        endcase
    end

    initial begin
        alu_q    = 8'd0;
        alu_cout = 1'b0;
    end
    always @(posedge clk) begin
        alu_q    <= alu_res[7:0];
        alu_cout <= alu_res[8];
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [1:0] i, input logic [2:0] c,
                                 input logic [7:0] a, input logic [7:0] b);
        req_ctl[4'(i) * 4'd3 +: 3] = c;
        req_a[{i, 3'b000} +: 8]    = a;
        req_b[{i, 3'b000} +: 8]    = b;
        req_valid[i]               = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [1:0] rrOrder [5];

    initial begin
        rrOrder   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst_n     = 1'b0;
        req_valid = '0;
        req_ctl   = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        step();
        step();

        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_alu_ctl",   32'(alu_ctl),   32'h0);
        checkOutput("rst_alu_a",     32'(alu_a),     32'h0);
        checkOutput("rst_alu_b",     32'(alu_b),     32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_id",    32'(rsp_id),    32'h0);
        checkOutput("rst_rsp_q",     32'(rsp_q),     32'h0);
        checkOutput("rst_rsp_cout",  32'(rsp_cout),  32'h0);
        checkOutput("rst_rsp_err",   32'(rsp_err),   32'h0);
        checkOutput("rst_busy",      32'(busy),      32'h0);
        checkOutput("rst_ops_done",  32'(ops_done),  32'h0);
        rst_n = 1'b1;
        step();

        // Add with carry: 200 + 100 = 300 = 0x12C
        applyStimulus(2'd0, 3'b000, 8'd200, 8'd100);
        #1;
        checkOutput("add_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        checkOutput("add_exec_busy",  32'(busy),      32'h1);
        checkOutput("add_exec_ctl",   32'(alu_ctl),   32'h0);
        checkOutput("add_exec_a",     32'(alu_a),     32'd200);
        checkOutput("add_exec_b",     32'(alu_b),     32'd100);
        checkOutput("add_exec_valid", 32'(rsp_valid), 32'h0);
        step();
        checkOutput("add_wait_valid", 32'(rsp_valid), 32'h0);
        step();
        checkOutput("add_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("add_rsp_id",    32'(rsp_id),    32'h0);
        checkOutput("add_rsp_q",     32'(rsp_q),     32'h2C);
        checkOutput("add_rsp_cout",  32'(rsp_cout),  32'h1);
        checkOutput("add_rsp_err",   32'(rsp_err),   32'h0);
        rsp_ready = 1'b1;
        step();
        checkOutput("add_done_valid", 32'(rsp_valid), 32'h0);
        checkOutput("add_ops_done",   32'(ops_done),  32'h1);
        checkOutput("add_done_busy",  32'(busy),      32'h0);

        // Reset pulse in IDLE restores ptr so requester 0 leads the round-robin.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        checkOutput("pulse_ops_done", 32'(ops_done), 32'h0);

        // Round-robin: 5 - 7 = -2 -> 0x1FE
        for (int k = 0; k < 4; k++) applyStimulus(2'(k), 3'b001, 8'd5, 8'd7);
        for (int n = 0; n < 5; n++) begin
            #1;
            checkOutput($sformatf("rr%0d_req_ready", n), 32'(req_ready), 32'(4'b0001 << rrOrder[n]));
            step();
            step();
            step();
            checkOutput($sformatf("rr%0d_valid", n), 32'(rsp_valid), 32'h1);
            checkOutput($sformatf("rr%0d_id", n),    32'(rsp_id),    32'(rrOrder[n]));
            checkOutput($sformatf("rr%0d_q", n),     32'(rsp_q),     32'hFE);
            checkOutput($sformatf("rr%0d_cout", n),  32'(rsp_cout),  32'h1);
            step();
        end
        checkOutput("rr_ops_done", 32'(ops_done), 32'd5);
        req_valid = '0;

        // Divide-by-zero then a legal divide from requester 2.
        applyStimulus(2'd2, 3'b011, 8'd9, 8'd0);
        step();
        req_valid = '0;
        checkOutput("div0_exec_ctl", 32'(alu_ctl), 32'h0);
        step();
        step();
        checkOutput("div0_id",   32'(rsp_id),   32'h2);
        checkOutput("div0_q",    32'(rsp_q),    32'hFF);
        checkOutput("div0_cout", 32'(rsp_cout), 32'h0);
        checkOutput("div0_err",  32'(rsp_err),  32'h1);
        step();
        applyStimulus(2'd2, 3'b011, 8'd9, 8'd2);
        step();
        req_valid = '0;
        checkOutput("div_exec_ctl", 32'(alu_ctl), 32'h3);
        step();
        step();
        checkOutput("div_id",   32'(rsp_id),   32'h2);
        checkOutput("div_q",    32'(rsp_q),    32'h04);
        checkOutput("div_cout", 32'(rsp_cout), 32'h0);
        checkOutput("div_err",  32'(rsp_err),  32'h0);
        step();

        // Backpressure: 16 * 17 = 272 = 0x110; req0 (3 + 4 via op 100) waits.
        rsp_ready = 1'b0;
        applyStimulus(2'd1, 3'b010, 8'd16, 8'd17);
        step();
        req_valid = '0;
        applyStimulus(2'd0, 3'b100, 8'd3, 8'd4);
        #1;
        checkOutput("bp_exec_req_ready", 32'(req_ready), 32'h0);
        step();
        checkOutput("bp_wait_req_ready", 32'(req_ready), 32'h0);
        step();
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("bp%0d_valid", c),     32'(rsp_valid), 32'h1);
            checkOutput($sformatf("bp%0d_id", c),        32'(rsp_id),    32'h1);
            checkOutput($sformatf("bp%0d_q", c),         32'(rsp_q),     32'h10);
            checkOutput($sformatf("bp%0d_cout", c),      32'(rsp_cout),  32'h1);
            checkOutput($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        checkOutput("bp_done_valid",     32'(rsp_valid), 32'h0);
        checkOutput("bp_ops_done",       32'(ops_done),  32'd8);
        checkOutput("bp_idle_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        step();
        checkOutput("bp_req0_id", 32'(rsp_id), 32'h0);
        checkOutput("bp_req0_q",  32'(rsp_q),  32'h07);
        step();
        checkOutput("bp_req0_ops_done", 32'(ops_done), 32'd9);

        // Reset asserted during WAIT drops the op immediately.
        applyStimulus(2'd3, 3'b000, 8'd1, 8'd2);
        step();
        req_valid = '0;
        step();
        checkOutput("mid_wait_busy", 32'(busy), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_busy",      32'(busy),      32'h0);
        checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("mid_alu_ctl",   32'(alu_ctl),   32'h0);
        checkOutput("mid_alu_a",     32'(alu_a),     32'h0);
        checkOutput("mid_alu_b",     32'(alu_b),     32'h0);
        checkOutput("mid_rsp_q",     32'(rsp_q),     32'h0);
        checkOutput("mid_ops_done",  32'(ops_done),  32'h0);
        checkOutput("mid_req_ready", 32'(req_ready), 32'h0);
        applyStimulus(2'd3, 3'b101, 8'd10, 8'd20);
        applyStimulus(2'd0, 3'b000, 8'd50, 8'd60);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        checkOutput("post_rst_exec_valid", 32'(rsp_valid), 32'h0);
        step();
        step();
        checkOutput("post_rst_id", 32'(rsp_id), 32'h0);
        checkOutput("post_rst_q",  32'(rsp_q),  32'h6E);
        step();
        checkOutput("post_rst_ops_done",  32'(ops_done),  32'd1);
        checkOutput("post_rst_req_ready3", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        checkOutput("pass_op_ctl", 32'(alu_ctl), 32'h5);
        step();
        step();
        checkOutput("pass_op_id", 32'(rsp_id), 32'h3);
        checkOutput("pass_op_q",  32'(rsp_q),  32'h1E);
        step();
        checkOutput("pass_op_ops_done", 32'(ops_done), 32'd2);

        // Counter wrap: preload the count, then one completion rolls it to zero.
        force dut.ops_done_q = 16'hFFFF;
        #1;
        release dut.ops_done_q;
        checkOutput("wrap_preload", 32'(ops_done), 32'hFFFF);
        applyStimulus(2'd1, 3'b000, 8'd1, 8'd1);
        step();
        req_valid = '0;
        step();
        step();
        checkOutput("wrap_q", 32'(rsp_q), 32'h02);
        step();
        checkOutput("wrap_ops_done", 32'(ops_done), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
